// File: rtl/cmplx_rotator_if.sv
// -----------------------------------------------------------------------------
// cmplx_rotator_if
//   Bundles the sample/twiddle input handshake, the mode controls and the
//   rotated-output handshake of cmplx_rotator.
//
//   master : producer/consumer side (drives inputs, out_ready, clr_ovf)
//   slave  : rotator side (drives in_ready and all out_* / ovf)
//
//   Signals
//     in_valid / in_ready        input handshake
//     in_re, in_im               sample x to rotate            (WIDTH, signed)
//     pass_re, pass_im           other butterfly leg            (WIDTH, signed)
//     tw_c, tw_s                 twiddle cos / sin              (CW, signed)
//     inverse                    0: x*(c - js), 1: x*(c + js)
//     bypass                     1: y = x
//     clr_ovf                    synchronous clear of ovf
//     out_valid / out_ready      output handshake
//     out_re, out_im             rotated sample y               (WIDTH, signed)
//     pass_out_re, pass_out_im   pass leg aligned with y        (WIDTH, signed)
//     ovf                        sticky overflow flag
// -----------------------------------------------------------------------------
interface cmplx_rotator_if #(
    parameter int WIDTH = 12,
    parameter int CW    = 12
);
    logic                    in_valid;
    logic                    in_ready;
    logic signed [WIDTH-1:0] in_re;
    logic signed [WIDTH-1:0] in_im;
    logic signed [WIDTH-1:0] pass_re;
    logic signed [WIDTH-1:0] pass_im;
    logic signed [CW-1:0]    tw_c;
    logic signed [CW-1:0]    tw_s;
    logic                    inverse;
    logic                    bypass;
    logic                    clr_ovf;
    logic                    out_valid;
    logic                    out_ready;
    logic signed [WIDTH-1:0] out_re;
    logic signed [WIDTH-1:0] out_im;
    logic signed [WIDTH-1:0] pass_out_re;
    logic signed [WIDTH-1:0] pass_out_im;
    logic                    ovf;

    modport master (
        output in_valid, in_re, in_im, pass_re, pass_im, tw_c, tw_s,
               inverse, bypass, clr_ovf, out_ready,
        input  in_ready, out_valid, out_re, out_im, pass_out_re, pass_out_im, ovf
    );

    modport slave (
        input  in_valid, in_re, in_im, pass_re, pass_im, tw_c, tw_s,
               inverse, bypass, clr_ovf, out_ready,
        output in_ready, out_valid, out_re, out_im, pass_out_re, pass_out_im, ovf
    );
endinterface

// File: rtl/cmplx_rotator.sv
// -----------------------------------------------------------------------------
// cmplx_rotator
//   Complex twiddle rotator for the FFT datapath. One complex sample per cycle
//   is multiplied by (c - js) (forward) or (c + js) (inverse) through a fixed
//   3-stage pipeline:
//     S1 : register x, pass leg, twiddle, mode bits
//     S2 : register the four partial products, pass leg, mode bits
//     S3 : add/sub, optional round-half-up, >>> FRAC, saturate or wrap,
//          write the output registers and the sticky overflow flag
//   The pass leg is only delayed so both butterfly legs leave aligned.
//
//   Flow control is a global stall: every stage (valid bits included)
//   advances only when the output register is empty or being consumed.
//
//   Ports
//     clk    rising-edge clock
//     rst_n  asynchronous active-low reset
//     bus    cmplx_rotator_if.slave (see interface header for signal list)
//
//   Parameters
//     WIDTH  data width, CW twiddle width, FRAC twiddle fraction bits,
//     ROUND  1 = round half up before the shift, 0 = truncate,
//     SAT    1 = saturate to WIDTH, 0 = keep the low WIDTH bits.
// -----------------------------------------------------------------------------
module cmplx_rotator #(
    parameter int WIDTH = 12,
    parameter int CW    = 12,
    parameter int FRAC  = 10,
    parameter int ROUND = 1,
    parameter int SAT   = 1
) (
    input logic            clk,
    input logic            rst_n,
    cmplx_rotator_if.slave bus
);

    // Product width and sum width (sum of two products cannot overflow SW).
    localparam int PW = WIDTH + CW;
    localparam int SW = PW + 1;

    localparam logic signed [WIDTH-1:0] Y_MAX  = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic signed [WIDTH-1:0] Y_MIN  = {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic signed [SW-1:0]    LIM_HI = SW'(Y_MAX);
    localparam logic signed [SW-1:0]    LIM_LO = SW'(Y_MIN);
    localparam logic signed [SW-1:0]    RND_K  = (ROUND != 0) ? SW'(2 ** (FRAC - 1)) : '0;

    // ------------------------------------------------------------------
    // Global stall
    // ------------------------------------------------------------------
    logic w_en;
    logic r_out_valid;

    assign w_en         = !r_out_valid || bus.out_ready;
    assign bus.in_ready = w_en;

    // ------------------------------------------------------------------
    // S1: input capture
    // ------------------------------------------------------------------
    logic                    r1_valid;
    logic signed [WIDTH-1:0] r1_re;
    logic signed [WIDTH-1:0] r1_im;
    logic signed [WIDTH-1:0] r1_pre;
    logic signed [WIDTH-1:0] r1_pim;
    logic signed [CW-1:0]    r1_c;
    logic signed [CW-1:0]    r1_s;
    logic                    r1_inv;
    logic                    r1_byp;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r1_valid <= 1'b0;
            r1_re    <= '0;
            r1_im    <= '0;
            r1_pre   <= '0;
            r1_pim   <= '0;
            r1_c     <= '0;
            r1_s     <= '0;
            r1_inv   <= 1'b0;
            r1_byp   <= 1'b0;
        end else if (w_en) begin
            r1_valid <= bus.in_valid;
            r1_re    <= bus.in_re;
            r1_im    <= bus.in_im;
            r1_pre   <= bus.pass_re;
            r1_pim   <= bus.pass_im;
            r1_c     <= bus.tw_c;
            r1_s     <= bus.tw_s;
            r1_inv   <= bus.inverse;
            r1_byp   <= bus.bypass;
        end
    end

    // ------------------------------------------------------------------
    // S2: partial products (x carried along for the bypass path)
    // ------------------------------------------------------------------
    logic                    r2_valid;
    logic signed [PW-1:0]    r2_rc;   // x_re * c
    logic signed [PW-1:0]    r2_is;   // x_im * s
    logic signed [PW-1:0]    r2_ic;   // x_im * c
    logic signed [PW-1:0]    r2_rs;   // x_re * s
    logic signed [WIDTH-1:0] r2_xre;
    logic signed [WIDTH-1:0] r2_xim;
    logic signed [WIDTH-1:0] r2_pre;
    logic signed [WIDTH-1:0] r2_pim;
    logic                    r2_inv;
    logic                    r2_byp;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r2_valid <= 1'b0;
            r2_rc    <= '0;
            r2_is    <= '0;
            r2_ic    <= '0;
            r2_rs    <= '0;
            r2_xre   <= '0;
            r2_xim   <= '0;
            r2_pre   <= '0;
            r2_pim   <= '0;
            r2_inv   <= 1'b0;
            r2_byp   <= 1'b0;
        end else if (w_en) begin
            r2_valid <= r1_valid;
            r2_rc    <= PW'(r1_re) * PW'(r1_c);
            r2_is    <= PW'(r1_im) * PW'(r1_s);
            r2_ic    <= PW'(r1_im) * PW'(r1_c);
            r2_rs    <= PW'(r1_re) * PW'(r1_s);
            r2_xre   <= r1_re;
            r2_xim   <= r1_im;
            r2_pre   <= r1_pre;
            r2_pim   <= r1_pim;
            r2_inv   <= r1_inv;
            r2_byp   <= r1_byp;
        end
    end

    // ------------------------------------------------------------------
    // S3 combinational: combine, round, shift, range check
    // ------------------------------------------------------------------
    logic signed [SW-1:0] w_sum_re;
    logic signed [SW-1:0] w_sum_im;
    logic signed [SW-1:0] w_shr_re;
    logic signed [SW-1:0] w_shr_im;
    logic                 w_ovf_hit;

    function automatic logic out_of_range(input logic signed [SW-1:0] v);
        return (v > LIM_HI) || (v < LIM_LO);
    endfunction

    function automatic logic signed [WIDTH-1:0] fit(input logic signed [SW-1:0] v);
        logic signed [WIDTH-1:0] r;
        r = v[WIDTH-1:0];
        if (SAT != 0) begin
            if (v > LIM_HI) begin
                r = Y_MAX;
            end else if (v < LIM_LO) begin
                r = Y_MIN;
            end
        end
        return r;
    endfunction

    always_comb begin
        w_sum_re = '0;
        w_sum_im = '0;
        if (r2_inv) begin
            w_sum_re = SW'(r2_rc) - SW'(r2_is);
            w_sum_im = SW'(r2_ic) + SW'(r2_rs);
        end else begin
            w_sum_re = SW'(r2_rc) + SW'(r2_is);
            w_sum_im = SW'(r2_ic) - SW'(r2_rs);
        end
        w_shr_re  = (w_sum_re + RND_K) >>> FRAC;
        w_shr_im  = (w_sum_im + RND_K) >>> FRAC;
        w_ovf_hit = r2_valid && !r2_byp &&
                    (out_of_range(w_shr_re) || out_of_range(w_shr_im));
    end

    // ------------------------------------------------------------------
    // S3 registers: outputs and sticky overflow
    // ------------------------------------------------------------------
    logic signed [WIDTH-1:0] r_out_re;
    logic signed [WIDTH-1:0] r_out_im;
    logic signed [WIDTH-1:0] r_pout_re;
    logic signed [WIDTH-1:0] r_pout_im;
    logic                    r_ovf;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_valid <= 1'b0;
            r_out_re    <= '0;
            r_out_im    <= '0;
            r_pout_re   <= '0;
            r_pout_im   <= '0;
        end else if (w_en) begin
            r_out_valid <= r2_valid;
            r_out_re    <= r2_byp ? r2_xre : fit(w_shr_re);
            r_out_im    <= r2_byp ? r2_xim : fit(w_shr_im);
            r_pout_re   <= r2_pre;
            r_pout_im   <= r2_pim;
        end
    end

    // A new overflow takes priority over a simultaneous clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ovf <= 1'b0;
        end else if (w_en && w_ovf_hit) begin
            r_ovf <= 1'b1;
        end else if (bus.clr_ovf) begin
            r_ovf <= 1'b0;
        end
    end

    assign bus.out_valid   = r_out_valid;
    assign bus.out_re      = r_out_re;
    assign bus.out_im      = r_out_im;
    assign bus.pass_out_re = r_pout_re;
    assign bus.pass_out_im = r_pout_im;
    assign bus.ovf         = r_ovf;

endmodule

// File: tb/tb_cmplx_rotator.sv
// -----------------------------------------------------------------------------
// tb_cmplx_rotator
//   Bench for cmplx_rotator. Three instances share one stimulus stream:
//   the default build (ROUND=1, SAT=1), a truncating build (ROUND=0) and a
//   wrapping build (SAT=0). Expected values come from the sample plan
//   constants or from an integer reference model of the rotation.
// -----------------------------------------------------------------------------
module tb_cmplx_rotator;

    localparam int W  = 12;
    localparam int CL = 12;
    localparam int FR = 10;
    localparam int HI = (1 << (W - 1)) - 1;
    localparam int LO = -(1 << (W - 1));

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    cmplx_rotator_if #(.WIDTH(W), .CW(CL)) bus    ();
    cmplx_rotator_if #(.WIDTH(W), .CW(CL)) bus_r0 ();
    cmplx_rotator_if #(.WIDTH(W), .CW(CL)) bus_s0 ();

    assign bus_r0.in_valid  = bus.in_valid;   assign bus_s0.in_valid  = bus.in_valid;
    assign bus_r0.in_re     = bus.in_re;      assign bus_s0.in_re     = bus.in_re;
    assign bus_r0.in_im     = bus.in_im;      assign bus_s0.in_im     = bus.in_im;
    assign bus_r0.pass_re   = bus.pass_re;    assign bus_s0.pass_re   = bus.pass_re;
    assign bus_r0.pass_im   = bus.pass_im;    assign bus_s0.pass_im   = bus.pass_im;
    assign bus_r0.tw_c      = bus.tw_c;       assign bus_s0.tw_c      = bus.tw_c;
    assign bus_r0.tw_s      = bus.tw_s;       assign bus_s0.tw_s      = bus.tw_s;
    assign bus_r0.inverse   = bus.inverse;    assign bus_s0.inverse   = bus.inverse;
    assign bus_r0.bypass    = bus.bypass;     assign bus_s0.bypass    = bus.bypass;
    assign bus_r0.clr_ovf   = bus.clr_ovf;    assign bus_s0.clr_ovf   = bus.clr_ovf;
    assign bus_r0.out_ready = bus.out_ready;  assign bus_s0.out_ready = bus.out_ready;

    cmplx_rotator #(.WIDTH(W), .CW(CL), .FRAC(FR), .ROUND(1), .SAT(1)) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus));
    cmplx_rotator #(.WIDTH(W), .CW(CL), .FRAC(FR), .ROUND(0), .SAT(1)) dut_r0 (
        .clk(clk), .rst_n(rst_n), .bus(bus_r0));
    cmplx_rotator #(.WIDTH(W), .CW(CL), .FRAC(FR), .ROUND(1), .SAT(0)) dut_s0 (
        .clk(clk), .rst_n(rst_n), .bus(bus_s0));

    int n_checks = 0;
    int n_errors = 0;

    typedef struct {
        int yr;
        int yi;
        int pr;
        int pi;
    } exp_t;

    // ---------------- reference model ----------------
    function automatic int limit(input longint v, input bit sat);
        longint m;
        if (sat) begin
            if (v > HI) return HI;
            if (v < LO) return LO;
            return int'(v);
        end
        m = v & longint'((1 << W) - 1);
        if (m > HI) m = m - longint'(1 << W);
        return int'(m);
    endfunction

    function automatic void ref_rot(input int xr, input int xi, input int c, input int s,
                                    input bit inv, input bit byp, input bit rnd, input bit sat,
                                    output int yr, output int yi, output bit ov);
        longint ar, ai;
        if (byp) begin
            yr = xr; yi = xi; ov = 1'b0;
            return;
        end
        if (inv) begin
            ar = longint'(xr) * c - longint'(xi) * s;
            ai = longint'(xi) * c + longint'(xr) * s;
        end else begin
            ar = longint'(xr) * c + longint'(xi) * s;
            ai = longint'(xi) * c - longint'(xr) * s;
        end
        if (rnd) begin
            ar = ar + (longint'(1) << (FR - 1));
            ai = ai + (longint'(1) << (FR - 1));
        end
        ar = ar >>> FR;
        ai = ai >>> FR;
        ov = (ar > HI) || (ar < LO) || (ai > HI) || (ai < LO);
        yr = limit(ar, sat);
        yi = limit(ai, sat);
    endfunction

    // ---------------- drive helpers ----------------
    task automatic drive(input bit v, input int xr, input int xi, input int c, input int s,
                         input bit inv, input bit byp, input int pr, input int pi);
        bus.in_valid = v;
        bus.in_re    = W'(xr);
        bus.in_im    = W'(xi);
        bus.tw_c     = CL'(c);
        bus.tw_s     = CL'(s);
        bus.inverse  = inv;
        bus.bypass   = byp;
        bus.pass_re  = W'(pr);
        bus.pass_im  = W'(pi);
    endtask

    // Present one sample with the pipe empty and out_ready=1, then wait until
    // its result is on the outputs (sampled at the falling edge).
    task automatic go(input int xr, input int xi, input int c, input int s,
                      input bit inv, input bit byp, input int pr, input int pi);
        drive(1'b1, xr, xi, c, s, inv, byp, pr, pi);
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        @(negedge clk);
        n_checks++;
        if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1 || bus.ovf !== 1'b0) begin
            n_errors++;
            $display("FAIL reset_flags: out_valid=%0b in_ready=%0b ovf=%0b want 0 1 0",
                     bus.out_valid, bus.in_ready, bus.ovf);
        end
        n_checks++;
        if (bus.out_re !== '0 || bus.out_im !== '0 || bus.pass_out_re !== '0 || bus.pass_out_im !== '0) begin
            n_errors++;
            $display("FAIL reset_data: y=(%0d,%0d) pass=(%0d,%0d) want all 0",
                     bus.out_re, bus.out_im, bus.pass_out_re, bus.pass_out_im);
        end
        rst_n = 1'b1;
        @(negedge clk);
        n_checks++;
        if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
            n_errors++;
            $display("FAIL reset_release: out_valid=%0b in_ready=%0b want 0 1",
                     bus.out_valid, bus.in_ready);
        end
    endtask

    task automatic test_identity();
        drive(1'b1, 100, -50, 1024, 0, 1'b0, 1'b0, 7, 8);
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        @(negedge clk);
        n_checks++;
        if (bus.out_valid !== 1'b0) begin
            n_errors++;
            $display("FAIL identity_early1: out_valid=%0b want 0", bus.out_valid);
        end
        @(posedge clk); @(negedge clk);
        n_checks++;
        if (bus.out_valid !== 1'b0) begin
            n_errors++;
            $display("FAIL identity_early2: out_valid=%0b want 0", bus.out_valid);
        end
        @(posedge clk); @(negedge clk);
        n_checks++;
        if (bus.out_valid !== 1'b1 || int'(bus.out_re) != 100 || int'(bus.out_im) != -50 ||
            int'(bus.pass_out_re) != 7 || int'(bus.pass_out_im) != 8 || bus.ovf !== 1'b0) begin
            n_errors++;
            $display("FAIL identity: v=%0b y=(%0d,%0d) pass=(%0d,%0d) ovf=%0b want 1 (100,-50) (7,8) 0",
                     bus.out_valid, bus.out_re, bus.out_im, bus.pass_out_re, bus.pass_out_im, bus.ovf);
        end
        @(negedge clk);
        n_checks++;
        if (bus.out_valid !== 1'b0) begin
            n_errors++;
            $display("FAIL identity_single: out_valid=%0b want 0", bus.out_valid);
        end
    endtask

    task automatic test_rotation();
        go(100, -50, 0, 1024, 1'b0, 1'b0, 0, 0);
        n_checks++;
        if (int'(bus.out_re) != -50 || int'(bus.out_im) != -100) begin
            n_errors++;
            $display("FAIL rot_fwd: y=(%0d,%0d) want (-50,-100)", bus.out_re, bus.out_im);
        end
        go(100, -50, 0, 1024, 1'b1, 1'b0, 0, 0);
        n_checks++;
        if (int'(bus.out_re) != 50 || int'(bus.out_im) != 100) begin
            n_errors++;
            $display("FAIL rot_inv: y=(%0d,%0d) want (50,100)", bus.out_re, bus.out_im);
        end
    endtask

    task automatic test_rounding();
        go(1, 0, 512, 0, 1'b0, 1'b0, 0, 0);
        n_checks++;
        if (int'(bus.out_re) != 1 || int'(bus_r0.out_re) != 0) begin
            n_errors++;
            $display("FAIL round_pos: round=%0d trunc=%0d want 1 0", bus.out_re, bus_r0.out_re);
        end
        go(-1, 0, 512, 0, 1'b0, 1'b0, 0, 0);
        n_checks++;
        if (int'(bus.out_re) != 0 || int'(bus_r0.out_re) != -1) begin
            n_errors++;
            $display("FAIL round_neg: round=%0d trunc=%0d want 0 -1", bus.out_re, bus_r0.out_re);
        end
    endtask

    task automatic test_saturation();
        go(2047, 2047, 1024, 1024, 1'b0, 1'b0, 0, 0);
        n_checks++;
        if (int'(bus.out_re) != 2047 || int'(bus.out_im) != 0 || bus.ovf !== 1'b1) begin
            n_errors++;
            $display("FAIL sat_clip: y=(%0d,%0d) ovf=%0b want (2047,0) 1", bus.out_re, bus.out_im, bus.ovf);
        end
        n_checks++;
        if (int'(bus_s0.out_re) != -2 || int'(bus_s0.out_im) != 0 || bus_s0.ovf !== 1'b1) begin
            n_errors++;
            $display("FAIL sat_wrap: y=(%0d,%0d) ovf=%0b want (-2,0) 1", bus_s0.out_re, bus_s0.out_im, bus_s0.ovf);
        end
        go(10, 0, 1024, 0, 1'b0, 1'b0, 0, 0);
        n_checks++;
        if (int'(bus.out_re) != 10 || bus.ovf !== 1'b1) begin
            n_errors++;
            $display("FAIL ovf_sticky: y_re=%0d ovf=%0b want 10 1", bus.out_re, bus.ovf);
        end
        bus.clr_ovf = 1'b1;
        @(posedge clk); #1;
        bus.clr_ovf = 1'b0;
        @(negedge clk);
        n_checks++;
        if (bus.ovf !== 1'b0 || bus_s0.ovf !== 1'b0) begin
            n_errors++;
            $display("FAIL ovf_clear: ovf=%0b wrap_ovf=%0b want 0 0", bus.ovf, bus_s0.ovf);
        end
        // Clear lands on the same edge that writes the overflowing result.
        drive(1'b1, 2047, 2047, 1024, 1024, 1'b0, 1'b0, 0, 0);
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        @(posedge clk); #1;
        bus.clr_ovf = 1'b1;
        @(posedge clk); #1;
        bus.clr_ovf = 1'b0;
        @(negedge clk);
        n_checks++;
        if (bus.out_valid !== 1'b1 || bus.ovf !== 1'b1) begin
            n_errors++;
            $display("FAIL ovf_set_wins: out_valid=%0b ovf=%0b want 1 1", bus.out_valid, bus.ovf);
        end
        bus.clr_ovf = 1'b1;
        @(posedge clk); #1;
        bus.clr_ovf = 1'b0;
    endtask

    task automatic test_backpressure();
        int  sent = 0;
        int  got  = 0;
        bit  prev_stall = 1'b0;
        bit  acc;
        int  h_re = 0, h_im = 0, h_pr = 0, h_pi = 0;
        @(posedge clk); #1;
        for (int t = 1; t <= 40 && got < 6; t++) begin
            bus.out_ready = !(t >= 4 && t <= 8);
            if (sent < 6) drive(1'b1, sent + 1, 0, 1024, 0, 1'b0, 1'b0, sent + 1, -(sent + 1));
            else          bus.in_valid = 1'b0;
            @(negedge clk);
            if (prev_stall) begin
                n_checks++;
                if (int'(bus.out_re) != h_re || int'(bus.out_im) != h_im ||
                    int'(bus.pass_out_re) != h_pr || int'(bus.pass_out_im) != h_pi || bus.out_valid !== 1'b1) begin
                    n_errors++;
                    $display("FAIL bp_hold t=%0d: y=(%0d,%0d) pass=(%0d,%0d) want (%0d,%0d) (%0d,%0d)",
                             t, bus.out_re, bus.out_im, bus.pass_out_re, bus.pass_out_im, h_re, h_im, h_pr, h_pi);
                end
            end
            if (bus.out_valid && !bus.out_ready) begin
                n_checks++;
                if (bus.in_ready !== 1'b0) begin
                    n_errors++;
                    $display("FAIL bp_in_ready t=%0d: in_ready=%0b want 0", t, bus.in_ready);
                end
            end
            if (bus.out_valid && bus.out_ready) begin
                got++;
                n_checks++;
                if (int'(bus.out_re) != got || int'(bus.out_im) != 0 ||
                    int'(bus.pass_out_re) != got || int'(bus.pass_out_im) != -got) begin
                    n_errors++;
                    $display("FAIL bp_order #%0d: y=(%0d,%0d) pass=(%0d,%0d) want (%0d,0) (%0d,%0d)",
                             got, bus.out_re, bus.out_im, bus.pass_out_re, bus.pass_out_im, got, got, -got);
                end
            end
            prev_stall = bus.out_valid && !bus.out_ready;
            h_re = int'(bus.out_re);      h_im = int'(bus.out_im);
            h_pr = int'(bus.pass_out_re); h_pi = int'(bus.pass_out_im);
            acc = bus.in_valid && bus.in_ready;
            @(posedge clk); #1;
            if (acc) sent++;
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        @(negedge clk);
        n_checks++;
        if (got != 6 || sent != 6 || bus.out_valid !== 1'b0) begin
            n_errors++;
            $display("FAIL bp_count: got=%0d sent=%0d trailing_valid=%0b want 6 6 0", got, sent, bus.out_valid);
        end
    endtask

    task automatic test_back_to_back();
        exp_t q[$];
        exp_t e;
        bit   any_ov = 1'b0;
        bit   ov;
        int   xr, xi, c, s, pr, pi, yr, yi;
        bit   inv, byp;
        bus.clr_ovf = 1'b1;
        @(posedge clk); #1;
        bus.clr_ovf = 1'b0;
        for (int t = 0; t < 400; t++) begin
            bit drain;
            drain = (t >= 300);
            xr  = int'($urandom_range(0, 4095)) - 2048;
            xi  = int'($urandom_range(0, 4095)) - 2048;
            c   = int'($urandom_range(0, 4095)) - 2048;
            s   = int'($urandom_range(0, 4095)) - 2048;
            pr  = int'($urandom_range(0, 4095)) - 2048;
            pi  = int'($urandom_range(0, 4095)) - 2048;
            inv = 1'($urandom_range(0, 1));
            byp = ($urandom_range(0, 7) == 0);
            drive(!drain && ($urandom_range(0, 3) != 0), xr, xi, c, s, inv, byp, pr, pi);
            bus.out_ready = drain || ($urandom_range(0, 3) != 0);
            @(negedge clk);
            if (bus.out_valid && bus.out_ready) begin
                n_checks++;
                if (q.size() == 0) begin
                    n_errors++;
                    $display("FAIL rand_extra t=%0d: unexpected output y=(%0d,%0d)", t, bus.out_re, bus.out_im);
                end else begin
                    e = q.pop_front();
                    if (int'(bus.out_re) != e.yr || int'(bus.out_im) != e.yi ||
                        int'(bus.pass_out_re) != e.pr || int'(bus.pass_out_im) != e.pi) begin
                        n_errors++;
                        $display("FAIL rand_data t=%0d: y=(%0d,%0d) pass=(%0d,%0d) want (%0d,%0d) (%0d,%0d)",
                                 t, bus.out_re, bus.out_im, bus.pass_out_re, bus.pass_out_im,
                                 e.yr, e.yi, e.pr, e.pi);
                    end
                end
            end
            if (bus.in_valid && bus.in_ready) begin
                ref_rot(xr, xi, c, s, inv, byp, 1'b1, 1'b1, yr, yi, ov);
                any_ov = any_ov || ov;
                e.yr = yr; e.yi = yi; e.pr = pr; e.pi = pi;
                q.push_back(e);
            end
            @(posedge clk); #1;
        end
        bus.in_valid = 1'b0;
        @(negedge clk);
        n_checks++;
        if (q.size() != 0) begin
            n_errors++;
            $display("FAIL rand_drain: %0d results missing", q.size());
        end
        n_checks++;
        if (bus.ovf !== any_ov) begin
            n_errors++;
            $display("FAIL rand_ovf: ovf=%0b want %0b", bus.ovf, any_ov);
        end
    endtask

    task automatic test_reset_midstream();
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        drive(1'b1, 2047, 2047, 1024, 1024, 1'b0, 1'b0, 3, 3);
        @(posedge clk); #1;
        drive(1'b1, 1, 0, 1024, 0, 1'b0, 1'b0, 4, 4);
        @(posedge clk); #1;
        drive(1'b1, 2, 0, 1024, 0, 1'b0, 1'b0, 5, 5);
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        n_checks++;
        if (bus.out_valid !== 1'b1 || bus.ovf !== 1'b1 || int'(bus.out_re) != 2047) begin
            n_errors++;
            $display("FAIL rstmid_pre: out_valid=%0b ovf=%0b y_re=%0d want 1 1 2047",
                     bus.out_valid, bus.ovf, bus.out_re);
        end
        #2;
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (bus.out_valid !== 1'b0 || bus.ovf !== 1'b0 || bus.in_ready !== 1'b1 ||
            bus.out_re !== '0 || bus.out_im !== '0 || bus.pass_out_re !== '0 || bus.pass_out_im !== '0) begin
            n_errors++;
            $display("FAIL rstmid_async: v=%0b ovf=%0b rdy=%0b y=(%0d,%0d) pass=(%0d,%0d) want 0 0 1 zeros",
                     bus.out_valid, bus.ovf, bus.in_ready, bus.out_re, bus.out_im,
                     bus.pass_out_re, bus.pass_out_im);
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            n_checks++;
            if (bus.out_valid !== 1'b0) begin
                n_errors++;
                $display("FAIL rstmid_ghost cycle %0d: out_valid=%0b want 0", i, bus.out_valid);
            end
        end
        drive(1'b1, -2048, 2047, 300, -700, 1'b1, 1'b1, 9, -9);
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        @(negedge clk);
        n_checks++;
        if (bus.out_valid !== 1'b0) begin
            n_errors++;
            $display("FAIL rstmid_early1: out_valid=%0b want 0", bus.out_valid);
        end
        @(posedge clk); @(negedge clk);
        n_checks++;
        if (bus.out_valid !== 1'b0) begin
            n_errors++;
            $display("FAIL rstmid_early2: out_valid=%0b want 0", bus.out_valid);
        end
        @(posedge clk); @(negedge clk);
        n_checks++;
        if (bus.out_valid !== 1'b1 || int'(bus.out_re) != -2048 || int'(bus.out_im) != 2047 ||
            int'(bus.pass_out_re) != 9 || int'(bus.pass_out_im) != -9 || bus.ovf !== 1'b0) begin
            n_errors++;
            $display("FAIL rstmid_bypass: v=%0b y=(%0d,%0d) pass=(%0d,%0d) ovf=%0b want 1 (-2048,2047) (9,-9) 0",
                     bus.out_valid, bus.out_re, bus.out_im, bus.pass_out_re, bus.pass_out_im, bus.ovf);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n         = 1'b0;
        bus.clr_ovf   = 1'b0;
        bus.out_ready = 1'b1;
        drive(1'b0, 0, 0, 0, 0, 1'b0, 1'b0, 0, 0);
        test_reset();
        test_identity();
        test_rotation();
        test_rounding();
        test_saturation();
        test_backpressure();
        test_back_to_back();
        test_reset_midstream();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
